// File: rtl/mano_io_pkg.sv
// Shared definitions for the Mano terminal I/O device.
//   CHAR_W      : width of one character (8 bits)
//   in_state_t  : input-side handshake FSM states
//   out_state_t : output-side handshake FSM states
package mano_io_pkg;

    localparam int CHAR_W = 8;

    typedef enum logic [1:0] {
        IN_IDLE,
        IN_WAIT_SET,
        IN_WAIT_CLR,
        IN_GAP
    } in_state_t;

    typedef enum logic [1:0] {
        OUT_ACK,
        OUT_WAIT,
        OUT_IDLE,
        OUT_PUSH
    } out_state_t;

endpackage

// File: rtl/mano_char_fifo.sv
// Small synchronous character FIFO, one per direction of the terminal.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push, data : write request / character; ignored when full
//   pop        : read request; ignored when empty
//   head       : oldest character, forced to zero while empty
//   full/empty : occupancy flags
module mano_char_fifo
    import mano_io_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [CHAR_W-1:0] data,
    input  logic              pop,
    output logic [CHAR_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CHAR_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    // Storage carries no reset; the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data;
    end

    // DEPTH is a power of two, so pointer increments wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mano_term_io.sv
// Terminal model for the Mano machine character I/O: buffers host bytes
// toward INPR under the FGI handshake and collects OUTR bytes toward the
// host under the FGO handshake.
//   io_clock, io_reset          : clock, synchronous active-high reset
//   host_rx_data/valid/ready    : host -> processor byte stream
//   host_tx_data/valid/ready    : processor -> host byte stream
//   cpu_fgi, cpu_fgo, cpu_outr  : processor flag states and OUTR
//   io_inpr, io_fgiset          : registered INPR value and FGI set pulse
//   io_fgoset                   : registered FGO set pulse
module mano_term_io
    import mano_io_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int CHAR_GAP = 2
) (
    input  logic              io_clock,
    input  logic              io_reset,
    input  logic [CHAR_W-1:0] host_rx_data,
    input  logic              host_rx_valid,
    output logic              host_rx_ready,
    output logic [CHAR_W-1:0] host_tx_data,
    output logic              host_tx_valid,
    input  logic              host_tx_ready,
    input  logic              cpu_fgi,
    input  logic              cpu_fgo,
    input  logic [CHAR_W-1:0] cpu_outr,
    output logic [CHAR_W-1:0] io_inpr,
    output logic              io_fgiset,
    output logic              io_fgoset
);

    localparam int GAP_W = (CHAR_GAP > 1) ? $clog2(CHAR_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((CHAR_GAP > 0) ? CHAR_GAP - 1 : 0);

    logic [CHAR_W-1:0] rx_head;
    logic              rx_full;
    logic              rx_empty;
    logic              rx_pop;
    logic              tx_full;
    logic              tx_empty;
    logic              tx_push;

    in_state_t         in_st, in_nxt;
    logic [GAP_W-1:0]  gap_cnt, gap_nxt;
    logic [CHAR_W-1:0] inpr_nxt;
    logic              fgiset_nxt;

    out_state_t        out_st, out_nxt;
    logic [CHAR_W-1:0] cap, cap_nxt;
    logic              fgoset_nxt;

    assign host_rx_ready = ~rx_full;
    assign host_tx_valid = ~tx_empty;

    mano_char_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk   (io_clock),
        .rst   (io_reset),
        .push  (host_rx_valid),
        .data  (host_rx_data),
        .pop   (rx_pop),
        .head  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    mano_char_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk   (io_clock),
        .rst   (io_reset),
        .push  (tx_push),
        .data  (cap),
        .pop   (host_tx_ready),
        .head  (host_tx_data),
        .full  (tx_full),
        .empty (tx_empty)
    );

    // Input side: present one character, wait for the processor to take
    // FGI high and back low (INP executed), then hold off CHAR_GAP cycles.
    always_comb begin
        in_nxt     = in_st;
        gap_nxt    = gap_cnt;
        inpr_nxt   = io_inpr;
        fgiset_nxt = 1'b0;
        rx_pop     = 1'b0;
        case (in_st)
            IN_IDLE: begin
                if (!rx_empty && !cpu_fgi) begin
                    inpr_nxt   = rx_head;
                    fgiset_nxt = 1'b1;
                    rx_pop     = 1'b1;
                    in_nxt     = IN_WAIT_SET;
                end
            end
            IN_WAIT_SET: begin
                if (cpu_fgi) in_nxt = IN_WAIT_CLR;
            end
            IN_WAIT_CLR: begin
                if (!cpu_fgi) begin
                    gap_nxt = '0;
                    in_nxt  = (CHAR_GAP == 0) ? IN_IDLE : IN_GAP;
                end
            end
            IN_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_nxt = '0;
                    in_nxt  = IN_IDLE;
                end else begin
                    gap_nxt = gap_cnt + 1'b1;
                end
            end
            default: in_nxt = IN_IDLE;
        endcase
    end

    // Output side: FGO set means "device ready"; the processor's OUT clears
    // it, at which point OUTR is captured and queued. FGO is only re-set
    // once the byte is safely in the TX FIFO, so a full FIFO back-pressures
    // the processor instead of dropping characters.
    always_comb begin
        out_nxt    = out_st;
        cap_nxt    = cap;
        fgoset_nxt = 1'b0;
        tx_push    = 1'b0;
        case (out_st)
            OUT_ACK: begin
                fgoset_nxt = 1'b1;
                out_nxt    = OUT_WAIT;
            end
            OUT_WAIT: begin
                if (cpu_fgo) out_nxt = OUT_IDLE;
            end
            OUT_IDLE: begin
                if (!cpu_fgo) begin
                    cap_nxt = cpu_outr;
                    out_nxt = OUT_PUSH;
                end
            end
            OUT_PUSH: begin
                if (!tx_full) begin
                    tx_push = 1'b1;
                    out_nxt = OUT_ACK;
                end
            end
            default: out_nxt = OUT_ACK;
        endcase
    end

    always_ff @(posedge io_clock) begin
        if (io_reset) begin
            in_st     <= IN_IDLE;
            gap_cnt   <= '0;
            io_inpr   <= '0;
            io_fgiset <= 1'b0;
            out_st    <= OUT_ACK;
            cap       <= '0;
            io_fgoset <= 1'b0;
        end else begin
            in_st     <= in_nxt;
            gap_cnt   <= gap_nxt;
            io_inpr   <= inpr_nxt;
            io_fgiset <= fgiset_nxt;
            out_st    <= out_nxt;
            cap       <= cap_nxt;
            io_fgoset <= fgoset_nxt;
        end
    end

endmodule
